// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with a pedestrian crossing.
// Dwell timing counts timebase ticks; lamps are Moore-decoded and registered.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 8,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_local,
  input  logic       ped_req,
  output logic [1:0] M_H,
  output logic [1:0] L_R,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN   = 3'd0,
    MAIN_YELLOW  = 3'd1,
    ALLRED_1     = 3'd2,
    LOCAL_GREEN  = 3'd3,
    LOCAL_YELLOW = 3'd4,
    ALLRED_2     = 3'd5,
    PED_WALK     = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b11;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_RED    = 2'b00;

  // Gap-out is possible only once local green has run GREEN_MIN ticks.
  localparam bit          GAP_EN = (GREEN_MAX > GREEN_MIN);
  localparam int unsigned GAP_TH = GAP_EN ? (GREEN_MAX - 1 - GREEN_MIN) : 0;

  state_t             state;
  state_t             nxt_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               nxt_pend;
  logic               req;
  logic               done;
  logic               gap;

  // Dwell reload value (duration minus one) for the state being entered.
  function automatic logic [CNT_W-1:0] dwell_load(input state_t s);
    case (s)
      MAIN_YELLOW,
      LOCAL_YELLOW: dwell_load = CNT_W'(YELLOW_T - 1);
      ALLRED_1,
      ALLRED_2:     dwell_load = CNT_W'(ALLRED_T - 1);
      LOCAL_GREEN:  dwell_load = CNT_W'(GREEN_MAX - 1);
      PED_WALK:     dwell_load = CNT_W'(WALK_T - 1);
      default:      dwell_load = CNT_W'(GREEN_MIN - 1);
    endcase
  endfunction

  function automatic logic [1:0] main_lamp(input state_t s);
    case (s)
      MAIN_GREEN:  main_lamp = LAMP_GREEN;
      MAIN_YELLOW: main_lamp = LAMP_YELLOW;
      default:     main_lamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [1:0] local_lamp(input state_t s);
    case (s)
      LOCAL_GREEN:  local_lamp = LAMP_GREEN;
      LOCAL_YELLOW: local_lamp = LAMP_YELLOW;
      default:      local_lamp = LAMP_RED;
    endcase
  endfunction

  // Next state, dwell counter and pending-request latch.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pend  = ped_pending;
    req       = ped_pending | ped_req;
    done      = (cnt == '0);
    gap       = GAP_EN && !car_local && (cnt <= CNT_W'(GAP_TH));

    case (state)
      MAIN_GREEN: begin
        if (tick && done && (car_local || req)) nxt_state = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        if (tick && done) nxt_state = ALLRED_1;
      end
      ALLRED_1: begin
        if (tick && done) begin
          if (req)            nxt_state = PED_WALK;
          else if (car_local) nxt_state = LOCAL_GREEN;
          else                nxt_state = MAIN_GREEN;
        end
      end
      LOCAL_GREEN: begin
        if (tick && (done || gap)) nxt_state = LOCAL_YELLOW;
      end
      LOCAL_YELLOW: begin
        if (tick && done) nxt_state = ALLRED_2;
      end
      PED_WALK: begin
        if (tick && done) nxt_state = ALLRED_2;
      end
      ALLRED_2: begin
        if (tick && done) nxt_state = MAIN_GREEN;
      end
      default: nxt_state = MAIN_GREEN;
    endcase

    if (nxt_state != state)  nxt_cnt = dwell_load(nxt_state);
    else if (tick && !done)  nxt_cnt = cnt - CNT_W'(1);

    if (state != PED_WALK) begin
      if (nxt_state == PED_WALK) nxt_pend = 1'b0;
      else if (ped_req)          nxt_pend = 1'b1;
    end
  end

  // State register with registered lamp decode of the incoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MAIN_GREEN;
      cnt         <= CNT_W'(GREEN_MIN - 1);
      ped_pending <= 1'b0;
      M_H         <= LAMP_GREEN;
      L_R         <= LAMP_RED;
      walk        <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      ped_pending <= nxt_pend;
      M_H         <= main_lamp(nxt_state);
      L_R         <= local_lamp(nxt_state);
      walk        <= (nxt_state == PED_WALK);
    end
  end

  assign phase = 3'(state);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// compared against an elapsed-tick reference model of the phase rules.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YEL  = 2;
  localparam int ARED = 1;
  localparam int WLK  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       car_local = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] M_H;
  logic [1:0] L_R;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  // Reference model: phase number, ticks spent in phase, pending request.
  int m_ph = 0;
  int m_el = 0;
  int m_pend = 0;

  traffic_phase_scheduler #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL),
    .ALLRED_T(ARED), .WALK_T(WLK), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .car_local(car_local),
    .ped_req(ped_req), .M_H(M_H), .L_R(L_R), .walk(walk),
    .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic int dur_of(input int ph);
    case (ph)
      0: return GMIN;
      1, 4: return YEL;
      2, 5: return ARED;
      3: return GMAX;
      default: return WLK;
    endcase
  endfunction

  task automatic model_update(input logic t, input logic c, input logic p, input logic r);
    int  nph;
    bit  fin;
    bit  rq;
    if (r) begin
      m_ph = 0; m_el = 0; m_pend = 0;
      return;
    end
    nph = m_ph;
    rq  = (m_pend != 0) || p;
    fin = (m_el >= dur_of(m_ph) - 1);
    if (t) begin
      case (m_ph)
        0: if (fin && (c || rq)) nph = 1;
        1: if (fin) nph = 2;
        2: if (fin) nph = rq ? 6 : (c ? 3 : 0);
        3: if (fin || (!c && m_el >= GMIN)) nph = 4;
        4: if (fin) nph = 5;
        5: if (fin) nph = 0;
        default: if (fin) nph = 5;
      endcase
    end
    if (m_ph != 6) begin
      if (nph == 6)  m_pend = 0;
      else if (p)    m_pend = 1;
    end
    if (nph != m_ph) m_el = 0;
    else if (t)      m_el = m_el + 1;
    m_ph = nph;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int mh;
    int lr;
    mh = (m_ph == 0) ? 3 : (m_ph == 1) ? 2 : 0;
    lr = (m_ph == 3) ? 3 : (m_ph == 4) ? 2 : 0;
    chk("phase", 32'(phase), 32'(m_ph));
    chk("M_H", 32'(M_H), 32'(mh));
    chk("L_R", 32'(L_R), 32'(lr));
    chk("walk", 32'(walk), 32'(m_ph == 6));
    chk("ped_pending", 32'(ped_pending), 32'(m_pend));
  endtask

  task automatic step(input logic t, input logic c, input logic p, input logic r);
    @(negedge clk);
    tick = t; car_local = c; ped_req = p; rst = r;
    @(posedge clk);
    model_update(t, c, p, r);
    #1;
    check_all();
  endtask

  initial begin
    int seq[$];
    int n;
    logic car;

    // Idle: no requests keeps main green.
    step(1, 0, 0, 1);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    chk("idle_phase", 32'(phase), 32'd0);

    // Local max-out with a fixed expected phase sequence.
    for (int i = 0; i < GMIN; i++) seq.push_back(0);
    for (int i = 0; i < YEL; i++)  seq.push_back(1);
    for (int i = 0; i < ARED; i++) seq.push_back(2);
    for (int i = 0; i < GMAX; i++) seq.push_back(3);
    for (int i = 0; i < YEL; i++)  seq.push_back(4);
    for (int i = 0; i < ARED; i++) seq.push_back(5);
    seq.push_back(0);
    step(1, 1, 0, 1);
    chk("maxout_seq", 32'(phase), 32'(seq[0]));
    for (int i = 1; i < seq.size(); i++) begin
      step(1, 1, 0, 0);
      chk("maxout_seq", 32'(phase), 32'(seq[i]));
    end

    // Gap-out: car leaves late, then early.
    for (int drop = 5; drop >= 2; drop -= 3) begin
      step(1, 1, 0, 1);
      n = 0;
      while (m_ph != 3 && n < 20) begin step(1, 1, 0, 0); n++; end
      chk("reach_local_green", 32'(m_ph == 3), 32'd1);
      for (int i = 1; i < drop; i++) step(1, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    end

    // Pedestrian pulse at cycle 10, with presses during the walk.
    step(1, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("ped_latched", 32'(ped_pending), 32'd1);
    for (int i = 0; i < 12; i++) step(1, 0, logic'(m_ph == 6), 0);
    chk("ped_after_walk", 32'(ped_pending), 32'd0);

    // Reset in the middle of local green with a pending request.
    step(1, 1, 0, 1);
    n = 0;
    while (m_ph != 3 && n < 20) begin step(1, 1, 0, 0); n++; end
    step(1, 1, 1, 0);
    step(1, 1, 0, 1);
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_MH", 32'(M_H), 32'd3);
    chk("midrst_pend", 32'(ped_pending), 32'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Tick gating during main yellow.
    step(1, 1, 0, 1);
    n = 0;
    while (m_ph != 1 && n < 20) begin step(1, 1, 0, 0); n++; end
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("gated_phase", 32'(phase), 32'd1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Random traffic.
    car = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) car = ~car;
      step(logic'($urandom_range(0, 3) != 0), car,
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 149) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timed phase scheduler for a two-road intersection: main highway (M_H) and local road (L_R), plus a pedestrian crossing. It takes a local-road vehicle sensor, a pedestrian push-button and a slow timebase strobe. It sequences green/yellow/all-red/walk phases with programmable dwell times, minimum-green and maximum-green (gap-out) rules. It sits between the sensor/button synchronisers and the lamp drivers.

## Interface
- GREEN_MIN, 4: minimum green in ticks; applies to both roads.
- GREEN_MAX, 8: maximum local-road green in ticks.
- YELLOW_T, 2: yellow dwell in ticks.
- ALLRED_T, 1: all-red clearance in ticks.
- WALK_T, 3: pedestrian walk dwell in ticks.
- CNT_W, 8: dwell counter width.
- Legal parameters: all durations ≥1; GREEN_MAX ≥ GREEN_MIN; every duration−1 fits in CNT_W.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle timebase strobe; all dwell timing counts ticks only.
- car_local  in  1  level, local-road vehicle present.
- ped_req  in  1  pedestrian request, pulse or level.
- M_H  out  2  main lamp: 11 green, 10 yellow, 00 red.
- L_R  out  2  local lamp, same encoding.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  latched pedestrian request.
- phase  out  3  current state code.

## Operation
- States and phase codes: MAIN_GREEN 0, MAIN_YELLOW 1, ALLRED_1 2, LOCAL_GREEN 3, LOCAL_YELLOW 4, ALLRED_2 5, PED_WALK 6. Codes 7 and any illegal state go to MAIN_GREEN on the next clock.
- Lamp outputs, Moore-decoded from state:
  - MAIN_GREEN: M_H=11, L_R=00.
  - MAIN_YELLOW: M_H=10, L_R=00.
  - LOCAL_GREEN: M_H=00, L_R=11.
  - LOCAL_YELLOW: M_H=00, L_R=10.
  - ALLRED_1, ALLRED_2, PED_WALK: both 00.
  - walk=1 only in PED_WALK.
- Dwell counter cnt:
  - On entry to a state, load duration−1. For MAIN_GREEN the duration is GREEN_MIN; for LOCAL_GREEN it is GREEN_MAX.
  - On each tick with cnt>0, decrement. A plain timed state therefore lasts exactly its duration in ticks.
- req = ped_pending | ped_req.
- Transitions are evaluated only in cycles with tick=1:
  - MAIN_GREEN, cnt==0: if car_local|req go to MAIN_YELLOW; else hold with cnt at 0.
  - MAIN_YELLOW, cnt==0: go to ALLRED_1.
  - ALLRED_1, cnt==0: if req go to PED_WALK; else if car_local go to LOCAL_GREEN; else go to MAIN_GREEN (request withdrawn).
  - LOCAL_GREEN: go to LOCAL_YELLOW when cnt==0 (max-out), or when car_local==0 and cnt ≤ GREEN_MAX−1−GREEN_MIN (gap-out after minimum green).
  - LOCAL_YELLOW, cnt==0: go to ALLRED_2.
  - PED_WALK, cnt==0: go to ALLRED_2.
  - ALLRED_2, cnt==0: go to MAIN_GREEN.
- ped_pending:
  - Set on any cycle with ped_req=1 while state≠PED_WALK.
  - Cleared on the clock that enters PED_WALK. Clearing wins over a simultaneous ped_req.
  - ped_req during PED_WALK is ignored.
- A local car that is still waiting after a pedestrian phase is served in the next cycle through MAIN_GREEN.

## Timing
- Reset, synchronous, any state, mid-phase included: the clock edge with rst=1 forces:
  - state MAIN_GREEN, cnt=GREEN_MIN−1, ped_pending=0;
  - M_H=11, L_R=00, walk=0, phase=0.
  - Reset takes priority over tick and all inputs.
- State, cnt and ped_pending are registered. Outputs update on the clock edge that takes the transition, so they are visible in the cycle after the deciding tick.
- car_local and ped_req are sampled only at the clock edge. With tick=0 the state and cnt are frozen; only ped_pending may still set.
- tick every cycle is legal. No dwell is shorter than 1 tick.
- No input-to-output combinational path.

## Test plan
- Parameters for all tests: GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, WALK_T=3, tick held 1.
- Idle: rst pulse, then 30 cycles with no requests -> phase stays 0, M_H=11, L_R=00, walk=0.
- Local max-out: car_local=1 from reset -> phase 0 for 4 cycles, 1 for 2, 2 for 1, 3 for 8, 4 for 2, 5 for 1, then 0 again.
- Local gap-out: car_local drops after 5 cycles of LOCAL_GREEN -> LOCAL_YELLOW follows at that tick. Drop after 2 cycles -> LOCAL_GREEN is held until 4 ticks have elapsed.
- Pedestrian: single-cycle ped_req at cycle 10, car_local=0 -> ped_pending=1 the next cycle. Then sequence 1, 2, 6 (walk=1 for 3 cycles), 5, 0. ped_pending=0 from PED_WALK entry. A ped_req during walk leaves ped_pending=0.
- Reset mid-operation: rst=1 during LOCAL_GREEN with ped_pending=1 -> next cycle phase=0, M_H=11, L_R=00, ped_pending=0. Next MAIN_GREEN dwell is 4 ticks.
- Tick gating: tick=0 for 10 cycles during MAIN_YELLOW -> phase and lamps unchanged. Resuming tick completes the remaining yellow ticks exactly.
